// File: rtl/c2_decoder_bcd.sv
// Two's-complement to sign/magnitude/packed-BCD decoder using an iterative double-dabble.
// Optional Hamming-weight output (out_ones) is enabled by defining C2DEC_POPCOUNT_EN.
module c2_decoder_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_neg,
  output logic [WIDTH-1:0]      out_mag,
  output logic [4*DIGITS-1:0]   out_bcd
`ifdef C2DEC_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] out_ones
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   word_r;
  logic               neg_r;
  logic [WIDTH-1:0]   mag_r;
  logic [WIDTH-1:0]   mag_shift;
  logic [BCD_W-1:0]   bcd_r;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W-1:0]   bcd_adj;
  logic [WIDTH-1:0]   mag_calc;
`ifdef C2DEC_POPCOUNT_EN
  logic [CNT_W-1:0]   ones_acc;
`endif

  // The most negative word negates to itself, which reads correctly as an unsigned magnitude.
  assign mag_calc = word_r[WIDTH-1] ? (~word_r + WIDTH'(1)) : word_r;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    bcd_adj = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_neg   <= 1'b0;
      out_mag   <= '0;
      out_bcd   <= '0;
      word_r    <= '0;
      neg_r     <= 1'b0;
      mag_r     <= '0;
      mag_shift <= '0;
      bcd_r     <= '0;
      cnt       <= '0;
`ifdef C2DEC_POPCOUNT_EN
      out_ones  <= '0;
      ones_acc  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            word_r   <= in_data;
            in_ready <= 1'b0;
            state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          neg_r     <= word_r[WIDTH-1];
          mag_r     <= mag_calc;
          mag_shift <= mag_calc;
          bcd_r     <= '0;
          cnt       <= CNT_W'(WIDTH);
`ifdef C2DEC_POPCOUNT_EN
          ones_acc  <= '0;
`endif
          state     <= S_SHIFT;
        end

        S_SHIFT: begin
          if (cnt == '0) begin
            // Conversion finished: results become visible only on entry to DONE.
            out_valid <= 1'b1;
            out_neg   <= neg_r;
            out_mag   <= mag_r;
            out_bcd   <= bcd_r;
`ifdef C2DEC_POPCOUNT_EN
            out_ones  <= ones_acc;
`endif
            state     <= S_DONE;
          end else begin
            bcd_r     <= {bcd_adj[BCD_W-2:0], mag_shift[WIDTH-1]};
            mag_shift <= {mag_shift[WIDTH-2:0], 1'b0};
            cnt       <= cnt - 1'b1;
`ifdef C2DEC_POPCOUNT_EN
            // The captured word is no longer needed, so it doubles as the popcount shifter.
            ones_acc  <= ones_acc + CNT_W'(word_r[WIDTH-1]);
            word_r    <= {word_r[WIDTH-2:0], 1'b0};
`endif
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c2_decoder_bcd.sv
// Randomized self-checking bench for c2_decoder_bcd against an arithmetic reference model.
// Define C2DEC_POPCOUNT_EN to also check out_ones.
module tb_c2_decoder_bcd;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int OW = $clog2(W + 1);

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_neg;
  logic [W-1:0]     out_mag;
  logic [4*D-1:0]   out_bcd;
`ifdef C2DEC_POPCOUNT_EN
  logic [OW-1:0]    out_ones;
`endif

  int checks   = 0;
  int failures = 0;

  c2_decoder_bcd #(.WIDTH(W), .DIGITS(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_neg   (out_neg),
    .out_mag   (out_mag),
    .out_bcd   (out_bcd)
`ifdef C2DEC_POPCOUNT_EN
    ,
    .out_ones  (out_ones)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the signed value of the word.
  function automatic void model(input logic [W-1:0] x, output logic neg, output logic [W-1:0] mag,
                                output logic [4*D-1:0] bcd, output int ones);
    int s;
    int m;
    s = x[W-1] ? int'(x) - (1 << W) : int'(x);
    m = (s < 0) ? -s : s;
    neg = (s < 0);
    mag = W'(m);
    bcd = '0;
    for (int d = 0; d < D; d++) begin
      bcd[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    ones = 0;
    for (int b = 0; b < W; b++) ones += int'(x[b]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic neg, input logic [W-1:0] mag,
                              input logic [4*D-1:0] bcd, input int ones);
    check({tag, "_neg"}, 32'(out_neg), 32'(neg));
    check({tag, "_mag"}, 32'(out_mag), 32'(mag));
    check({tag, "_bcd"}, 32'(out_bcd), 32'(bcd));
`ifdef C2DEC_POPCOUNT_EN
    check({tag, "_ones"}, 32'(out_ones), 32'(ones));
`else
    if (ones < 0) $display("unexpected negative popcount");
`endif
  endtask

  // Send one word, wait for the result, hold out_ready low for 'hold' cycles, then release.
  task automatic do_word(input logic [W-1:0] x, input int hold);
    logic            e_neg;
    logic [W-1:0]    e_mag;
    logic [4*D-1:0]  e_bcd;
    int              e_ones;
    int              lat;
    model(x, e_neg, e_mag, e_bcd, e_ones);
    check("in_ready_before", 32'(in_ready), 32'd1);
    in_data   = x;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    in_data  = ~x;
    check("in_ready_busy", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(W + 2));
    check_result("res", e_neg, e_mag, e_bcd, e_ones);
    for (int k = 0; k < hold; k++) begin
      // A new word offered under backpressure must be ignored.
      in_valid = (k == 1);
      tick();
      in_valid = 1'b0;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check_result("bp", e_neg, e_mag, e_bcd, e_ones);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_valid", 32'(out_valid), 32'd0);
    check("hs_in_ready", 32'(in_ready), 32'd1);
    check_result("held", e_neg, e_mag, e_bcd, e_ones);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check_result("rst", 1'b0, '0, '0, 0);

    do_word(8'h35, 0);
    do_word(8'hCB, 0);
    do_word(8'hFF, 0);
    do_word(8'h80, 0);
    do_word(8'h7F, 0);
    do_word(8'h00, 0);
    do_word(8'hC6, 5);
    do_word(8'hED, 2);

    // Abort during the 4th SHIFT cycle.
    in_data  = 8'h5A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check_result("abort", 1'b0, '0, '0, 0);
    do_word(8'hCB, 0);

    // Reset and in_valid on the same edge: the word must not be captured.
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h44;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rst_vs_valid_ready", 32'(in_ready), 32'd1);
    repeat (W + 4) tick();
    check("rst_vs_valid_nores", 32'(out_valid), 32'd0);

    for (int n = 0; n < 40; n++) begin
      do_word(W'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
